// File: rtl/inv_key_expansion_if.sv
// Handshake and data bundle between a round-key consumer and inv_key_expansion.
// The key loader and consumer side uses master; the key scheduler uses slave.
interface inv_key_expansion_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_in;
  logic [DATA_WIDTH-1:0] key_in_0;
  logic [DATA_WIDTH-1:0] key_in_1;
  logic [DATA_WIDTH-1:0] key_in_2;
  logic [DATA_WIDTH-1:0] key_in_3;
  logic                  rk_ready_in;
  logic                  rk_valid_out;
  logic [3:0]            rk_round_out;
  logic [DATA_WIDTH-1:0] rk_out_0;
  logic [DATA_WIDTH-1:0] rk_out_1;
  logic [DATA_WIDTH-1:0] rk_out_2;
  logic [DATA_WIDTH-1:0] rk_out_3;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    output start_in, key_in_0, key_in_1, key_in_2, key_in_3, rk_ready_in,
    input  rk_valid_out, rk_round_out, rk_out_0, rk_out_1, rk_out_2, rk_out_3,
           busy_out, done_out
  );

  modport slave (
    input  start_in, key_in_0, key_in_1, key_in_2, key_in_3, rk_ready_in,
    output rk_valid_out, rk_round_out, rk_out_0, rk_out_1, rk_out_2, rk_out_3,
           busy_out, done_out
  );
endinterface

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: starting from the round-10 key, presents round
// keys 10 down to 0, one per ready/valid handshake, stepping the schedule backwards.
module inv_key_expansion #(
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  inv_key_expansion_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;

  // FIPS-197 forward S-box; entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_w0, r_w1, r_w2, r_w3;
  logic [3:0]            r_cnt;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [DATA_WIDTH-1:0] w_rot;
  logic [DATA_WIDTH-1:0] w_sub;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Previous round key, derived purely from the registered words and counter.
  always_comb begin
    w_n3  = r_w3 ^ r_w2;
    w_n2  = r_w2 ^ r_w1;
    w_n1  = r_w1 ^ r_w0;
    w_rot = {w_n3[DATA_WIDTH-9:0], w_n3[DATA_WIDTH-1 -: 8]};
    w_sub = '0;
    for (int i = 0; i < NB; i++) begin
      w_sub[8*i +: 8] = sbox(w_rot[8*i +: 8]);
    end
    w_n0  = r_w0 ^ w_sub ^ {rcon(r_cnt), {(DATA_WIDTH-8){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_in) begin
            r_w0    <= bus.key_in_0;
            r_w1    <= bus.key_in_1;
            r_w2    <= bus.key_in_2;
            r_w3    <= bus.key_in_3;
            r_cnt   <= 4'd10;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (bus.rk_ready_in) begin
            if (r_cnt != 4'd0) begin
              r_w0  <= w_n0;
              r_w1  <= w_n1;
              r_w2  <= w_n2;
              r_w3  <= w_n3;
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rk_valid_out = r_valid;
  assign bus.rk_round_out = r_cnt;
  assign bus.rk_out_0     = r_w0;
  assign bus.rk_out_1     = r_w1;
  assign bus.rk_out_2     = r_w2;
  assign bus.rk_out_3     = r_w3;
  assign bus.busy_out     = r_busy;
  assign bus.done_out     = r_done;

endmodule
